// File: rtl/acc_core.sv
// Two-cycle (fetch/execute) accumulator core with a small register file, flags,
// conditional jumps, an external input port and a strobed output port.
module acc_core #(
  parameter int unsigned WIDTH      = 8,
  parameter int unsigned NREGS      = 4,
  parameter int unsigned PROG_DEPTH = 256
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          en,
  output logic [$clog2(PROG_DEPTH)-1:0] instr_addr,
  input  logic [WIDTH+3:0]              instr_data,
  input  logic [WIDTH-1:0]              ext_in,
  output logic [WIDTH-1:0]              acc,
  output logic                          zero,
  output logic                          carry,
  output logic [WIDTH-1:0]              out_data,
  output logic                          out_valid,
  output logic                          halted
);

  localparam int unsigned PC_W = $clog2(PROG_DEPTH);

  typedef enum logic [1:0] {
    StFetch,
    StExec,
    StHalted
  } state_e;

  typedef enum logic [3:0] {
    OpNop  = 4'h0,
    OpLdi  = 4'h1,
    OpLd   = 4'h2,
    OpSt   = 4'h3,
    OpAdd  = 4'h4,
    OpSub  = 4'h5,
    OpAnd  = 4'h6,
    OpOr   = 4'h7,
    OpXor  = 4'h8,
    OpAddi = 4'h9,
    OpIn   = 4'hA,
    OpOut  = 4'hB,
    OpJmp  = 4'hC,
    OpJz   = 4'hD,
    OpJc   = 4'hE,
    OpHalt = 4'hF
  } opcode_e;

  state_e            state_q, state_d;
  logic [PC_W-1:0]   pc_q, pc_d;
  logic [WIDTH+3:0]  ir_q, ir_d;
  logic [WIDTH-1:0]  acc_q, acc_d;
  logic              zero_q, zero_d;
  logic              carry_q, carry_d;
  logic [WIDTH-1:0]  out_data_q, out_data_d;
  logic              out_valid_q, out_valid_d;
  logic              halted_q, halted_d;
  logic [WIDTH-1:0]  regs_q [NREGS];
  logic [WIDTH-1:0]  regs_d [NREGS];

  // Instruction decode
  opcode_e           op;
  logic [WIDTH-1:0]  imm;
  logic [3:0]        sel;
  logic [PC_W-1:0]   jmp_tgt;
  logic [PC_W-1:0]   pc_inc;

  assign op      = opcode_e'(ir_q[WIDTH+3:WIDTH]);
  assign imm     = ir_q[WIDTH-1:0];
  assign sel     = imm[3:0];
  assign jmp_tgt = imm[PC_W-1:0];
  assign pc_inc  = (pc_q == PC_W'(PROG_DEPTH - 1)) ? '0 : pc_q + 1'b1;

  // Out-of-range selects match no entry, so they read as zero
  logic [WIDTH-1:0]  reg_rdata;

  always_comb begin
    reg_rdata = '0;
    for (int i = 0; i < NREGS; i++) begin
      if (sel == 4'(i)) begin
        reg_rdata = regs_q[i];
      end
    end
  end

  // Arithmetic with one extra bit for carry/borrow
  logic [WIDTH:0]    sum_add;
  logic [WIDTH:0]    sum_sub;
  logic [WIDTH:0]    sum_addi;

  always_comb begin
    sum_add  = {1'b0, acc_q} + {1'b0, reg_rdata};
    sum_sub  = {1'b0, acc_q} - {1'b0, reg_rdata};
    sum_addi = {1'b0, acc_q} + {1'b0, imm};
  end

  // Next-state logic
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    ir_d        = ir_q;
    acc_d       = acc_q;
    zero_d      = zero_q;
    carry_d     = carry_q;
    out_data_d  = out_data_q;
    out_valid_d = 1'b0;
    halted_d    = halted_q;
    for (int i = 0; i < NREGS; i++) begin
      regs_d[i] = regs_q[i];
    end

    unique case (state_q)
      StFetch: begin
        if (en) begin
          ir_d    = instr_data;
          state_d = StExec;
        end
      end

      StExec: begin
        if (en) begin
          state_d = StFetch;
          pc_d    = pc_inc;
          unique case (op)
            OpNop: ;
            OpLdi: begin
              acc_d  = imm;
              zero_d = (imm == '0);
            end
            OpLd: begin
              acc_d  = reg_rdata;
              zero_d = (reg_rdata == '0);
            end
            OpSt: begin
              for (int i = 0; i < NREGS; i++) begin
                if (sel == 4'(i)) begin
                  regs_d[i] = acc_q;
                end
              end
            end
            OpAdd: begin
              acc_d   = sum_add[WIDTH-1:0];
              zero_d  = (sum_add[WIDTH-1:0] == '0);
              carry_d = sum_add[WIDTH];
            end
            OpSub: begin
              acc_d   = sum_sub[WIDTH-1:0];
              zero_d  = (sum_sub[WIDTH-1:0] == '0);
              carry_d = sum_sub[WIDTH];
            end
            OpAnd: begin
              acc_d  = acc_q & reg_rdata;
              zero_d = ((acc_q & reg_rdata) == '0);
            end
            OpOr: begin
              acc_d  = acc_q | reg_rdata;
              zero_d = ((acc_q | reg_rdata) == '0);
            end
            OpXor: begin
              acc_d  = acc_q ^ reg_rdata;
              zero_d = ((acc_q ^ reg_rdata) == '0);
            end
            OpAddi: begin
              acc_d   = sum_addi[WIDTH-1:0];
              zero_d  = (sum_addi[WIDTH-1:0] == '0);
              carry_d = sum_addi[WIDTH];
            end
            OpIn: begin
              acc_d  = ext_in;
              zero_d = (ext_in == '0);
            end
            OpOut: begin
              out_data_d  = acc_q;
              out_valid_d = 1'b1;
            end
            OpJmp: pc_d = jmp_tgt;
            OpJz: begin
              if (zero_q) pc_d = jmp_tgt;
            end
            OpJc: begin
              if (carry_q) pc_d = jmp_tgt;
            end
            OpHalt: begin
              pc_d     = pc_q;
              halted_d = 1'b1;
              state_d  = StHalted;
            end
          endcase
        end
      end

      StHalted: ;

      default: state_d = StFetch;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StFetch;
      pc_q        <= '0;
      ir_q        <= '0;
      acc_q       <= '0;
      zero_q      <= 1'b0;
      carry_q     <= 1'b0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      halted_q    <= 1'b0;
      for (int i = 0; i < NREGS; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      ir_q        <= ir_d;
      acc_q       <= acc_d;
      zero_q      <= zero_d;
      carry_q     <= carry_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      halted_q    <= halted_d;
      for (int i = 0; i < NREGS; i++) begin
        regs_q[i] <= regs_d[i];
      end
    end
  end

  assign instr_addr = pc_q;
  assign acc        = acc_q;
  assign zero       = zero_q;
  assign carry      = carry_q;
  assign out_data   = out_data_q;
  assign out_valid  = out_valid_q;
  assign halted     = halted_q;

endmodule

// File: tb/tb_acc_core.sv
// Directed bench for acc_core: hand-assembled programs in a bench-side ROM,
// expected values worked out by hand from the instruction semantics.
module tb_acc_core;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic [7:0]  instr_addr;
  logic [11:0] instr_data;
  logic [7:0]  ext_in;
  logic [7:0]  acc;
  logic        zero;
  logic        carry;
  logic [7:0]  out_data;
  logic        out_valid;
  logic        halted;

  logic [11:0] mem [256];
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  assign instr_data = mem[instr_addr];

  acc_core #(
    .WIDTH      (8),
    .NREGS      (4),
    .PROG_DEPTH (256)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .instr_addr (instr_addr),
    .instr_data (instr_data),
    .ext_in     (ext_in),
    .acc        (acc),
    .zero       (zero),
    .carry      (carry),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .halted     (halted)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 256; i++) mem[i] = 12'h000;
  endtask

  // Assert reset, then release it 1 time unit after a rising edge
  task automatic restart();
    rst = 1'b1;
    #1;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    rst    = 1'b0;
    en     = 1'b1;
    ext_in = 8'h00;
    clear_mem();
    #2 rst = 1'b1;
    #1;
    check("rst_acc",       32'(acc),        32'h00);
    check("rst_pc",        32'(instr_addr), 32'h00);
    check("rst_zero",      32'(zero),       32'h0);
    check("rst_carry",     32'(carry),      32'h0);
    check("rst_out_data",  32'(out_data),   32'h00);
    check("rst_out_valid", 32'(out_valid),  32'h0);
    check("rst_halted",    32'(halted),     32'h0);

    // Reset mid-EXEC of LDI 0x55
    mem[0] = 12'h112; mem[1] = 12'hB00; mem[2] = 12'h155;
    restart();
    tick(2);
    check("t1_acc_ldi",  32'(acc),        32'h12);
    check("t1_pc1",      32'(instr_addr), 32'h01);
    tick(2);
    check("t1_ov",       32'(out_valid),  32'h1);
    check("t1_od",       32'(out_data),   32'h12);
    tick(1);
    check("t1_ov_drop",  32'(out_valid),  32'h0);
    check("t1_pc2",      32'(instr_addr), 32'h02);
    #2 rst = 1'b1;
    #1;
    check("t1_async_acc", 32'(acc),        32'h00);
    check("t1_async_pc",  32'(instr_addr), 32'h00);
    check("t1_async_od",  32'(out_data),   32'h00);
    @(posedge clk);
    #1 rst = 1'b0;
    tick(2);
    check("t1_restart_acc", 32'(acc),        32'h12);
    check("t1_restart_pc",  32'(instr_addr), 32'h01);

    // Add with carry
    clear_mem();
    mem[0] = 12'h1F0; mem[1] = 12'h301; mem[2] = 12'h120; mem[3] = 12'h401;
    restart();
    tick(6);
    check("t2_acc_pre",   32'(acc),   32'h20);
    check("t2_carry_pre", 32'(carry), 32'h0);
    tick(2);
    check("t2_acc",   32'(acc),   32'h10);
    check("t2_carry", 32'(carry), 32'h1);
    check("t2_zero",  32'(zero),  32'h0);

    // Subtract, borrow, JZ/JC taken and JZ not taken
    clear_mem();
    mem[8'h00] = 12'h105; mem[8'h01] = 12'h300; mem[8'h02] = 12'h500; mem[8'h03] = 12'hD10;
    mem[8'h10] = 12'h103; mem[8'h11] = 12'h500; mem[8'h12] = 12'hE20;
    mem[8'h20] = 12'hD40;
    restart();
    tick(6);
    check("t3_sub_acc",   32'(acc),   32'h00);
    check("t3_sub_zero",  32'(zero),  32'h1);
    check("t3_sub_carry", 32'(carry), 32'h0);
    tick(2);
    check("t3_jz_taken", 32'(instr_addr), 32'h10);
    tick(4);
    check("t3_borrow_acc",   32'(acc),   32'hFE);
    check("t3_borrow_carry", 32'(carry), 32'h1);
    check("t3_borrow_zero",  32'(zero),  32'h0);
    tick(2);
    check("t3_jc_taken", 32'(instr_addr), 32'h20);
    tick(2);
    check("t3_jz_not_taken", 32'(instr_addr), 32'h21);

    // IN sampled at the EXEC edge, ADDI, OUT strobe, pending strobe with en low
    clear_mem();
    mem[0] = 12'hA00; mem[1] = 12'h901; mem[2] = 12'hB00; mem[3] = 12'hF00;
    ext_in = 8'h77;
    restart();
    tick(1);
    ext_in = 8'h01;
    tick(1);
    check("t4_in_acc", 32'(acc), 32'h01);
    tick(3);
    check("t4_addi_acc", 32'(acc),       32'h02);
    check("t4_ov_before", 32'(out_valid), 32'h0);
    tick(1);
    check("t4_ov",  32'(out_valid), 32'h1);
    check("t4_od",  32'(out_data),  32'h02);
    en = 1'b0;
    tick(1);
    check("t4_ov_drop_en_low", 32'(out_valid),  32'h0);
    tick(3);
    check("t4_pc_frozen",  32'(instr_addr), 32'h03);
    check("t4_not_halted", 32'(halted),     32'h0);
    en = 1'b1;
    tick(2);
    check("t4_halted",  32'(halted),     32'h1);
    check("t4_halt_pc", 32'(instr_addr), 32'h03);

    // en stall mid-EXEC and out-of-range register select
    clear_mem();
    mem[0] = 12'h133; mem[1] = 12'h309; mem[2] = 12'h144;
    mem[3] = 12'h201; mem[4] = 12'h144; mem[5] = 12'h209;
    restart();
    tick(3);
    check("t5_pc_pre_stall", 32'(instr_addr), 32'h01);
    en = 1'b0;
    tick(5);
    check("t5_stall_pc",  32'(instr_addr), 32'h01);
    check("t5_stall_acc", 32'(acc),        32'h33);
    en = 1'b1;
    tick(1);
    check("t5_resume_pc", 32'(instr_addr), 32'h02);
    tick(4);
    check("t5_r1_untouched", 32'(acc),  32'h00);
    check("t5_r1_zero",      32'(zero), 32'h1);
    tick(2);
    check("t5_ldi_zero", 32'(zero), 32'h0);
    tick(2);
    check("t5_ld_r9_acc",  32'(acc),  32'h00);
    check("t5_ld_r9_zero", 32'(zero), 32'h1);

    // PC wrap through 0xFF, then HALT ignores en and suppresses OUT
    clear_mem();
    mem[8'h00] = 12'hE10; mem[8'h01] = 12'h1FF; mem[8'h02] = 12'hCFE;
    mem[8'hFE] = 12'h901; mem[8'hFF] = 12'h000;
    mem[8'h10] = 12'hB00; mem[8'h11] = 12'hF00; mem[8'h12] = 12'hB00;
    restart();
    tick(6);
    check("t6_jmp_pc", 32'(instr_addr), 32'hFE);
    tick(2);
    check("t6_pc_ff",    32'(instr_addr), 32'hFF);
    check("t6_addi_c",   32'(carry),      32'h1);
    check("t6_addi_z",   32'(zero),       32'h1);
    tick(2);
    check("t6_wrap", 32'(instr_addr), 32'h00);
    tick(2);
    check("t6_jc_after_wrap", 32'(instr_addr), 32'h10);
    tick(2);
    check("t6_out", 32'(out_valid), 32'h1);
    tick(2);
    check("t6_halted", 32'(halted),     32'h1);
    check("t6_pc",     32'(instr_addr), 32'h11);
    for (int i = 0; i < 8; i++) begin
      en = i[0];
      tick(1);
      check("t6_halt_ov", 32'(out_valid),  32'h0);
      check("t6_halt_pc", 32'(instr_addr), 32'h11);
    end
    check("t6_still_halted", 32'(halted), 32'h1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
